wb_sdram_arbiter: RTL and testbench



---
 rtl/wb_pkg.sv | 23 ++
 rtl/rr_pick.sv | 36 +++
 rtl/wb_sdram_arbiter.sv | 131 +++++++++++++
 tb/tb_wb_sdram_arbiter.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Shared Wishbone B3 encodings and arbiter state type.
package wb_pkg;

   typedef enum logic [2:0] {
      CtiClassic = 3'b000,
      CtiConst   = 3'b001,
      CtiIncr    = 3'b010,
      CtiEob     = 3'b111
   } cti_e;

   typedef enum logic [1:0] {
      BteLinear = 2'b00,
      BteWrap4  = 2'b01,
      BteWrap8  = 2'b10,
      BteWrap16 = 2'b11
   } bte_e;

   typedef enum logic {
      StIdle,
      StBusy
   } arb_state_e;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first requester after last_i, wrapping modulo NR_OF_WBM.
module rr_pick #(
   parameter int unsigned NR_OF_WBM = 4
) (
   input  logic [NR_OF_WBM-1:0]         req_i,
   input  logic [$clog2(NR_OF_WBM)-1:0] last_i,
   output logic [NR_OF_WBM-1:0]         pick_o,
   output logic                         any_o
);

   localparam int unsigned IW = $clog2(NR_OF_WBM);
   localparam logic [IW:0] NrW = NR_OF_WBM[IW:0];

   logic [IW:0]   sum;
   logic [IW-1:0] idx;

   always_comb begin
      pick_o = '0;
      any_o  = 1'b0;
      sum    = '0;
      idx    = '0;
      // Offset 1..N from last_i, so last_i itself is considered last.
      for (int unsigned i = 1; i <= NR_OF_WBM; i++) begin
         sum = {1'b0, last_i} + i[IW:0];
         if (sum >= NrW) begin
            sum = sum - NrW;
         end
         idx = sum[IW-1:0];
         if (!any_o && req_i[idx]) begin
            pick_o[idx] = 1'b1;
            any_o       = 1'b1;
         end
      end
   end

endmodule

// File: rtl/wb_sdram_arbiter.sv
// Round-robin Wishbone B3 arbiter merging NR_OF_WBM masters onto one SDRAM controller port.
module wb_sdram_arbiter
   import wb_pkg::*;
#(
   parameter int unsigned NR_OF_WBM = 4,
   parameter int unsigned AW        = 30,
   parameter int unsigned DW        = 32
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [NR_OF_WBM*DW-1:0] m_dat_i,
   input  logic [NR_OF_WBM*AW-1:0] m_adr_i,
   input  logic [NR_OF_WBM*4-1:0]  m_sel_i,
   input  logic [NR_OF_WBM*3-1:0]  m_cti_i,
   input  logic [NR_OF_WBM*2-1:0]  m_bte_i,
   input  logic [NR_OF_WBM-1:0]    m_we_i,
   input  logic [NR_OF_WBM-1:0]    m_cyc_i,
   input  logic [NR_OF_WBM-1:0]    m_stb_i,
   output logic [DW-1:0]           m_dat_o,
   output logic [NR_OF_WBM-1:0]    m_ack_o,
   output logic [DW-1:0]           s_dat_o,
   output logic [AW-1:0]           s_adr_o,
   output logic [3:0]              s_sel_o,
   output logic [2:0]              s_cti_o,
   output logic [1:0]              s_bte_o,
   output logic                    s_we_o,
   output logic                    s_cyc_o,
   output logic                    s_stb_o,
   input  logic [DW-1:0]           s_dat_i,
   input  logic                    s_ack_i,
   output logic [NR_OF_WBM-1:0]    gnt_o
);

   localparam int unsigned IW         = $clog2(NR_OF_WBM);
   localparam int unsigned LastRstInt = NR_OF_WBM - 1;
   localparam logic [IW-1:0] LastRst  = LastRstInt[IW-1:0];

   arb_state_e             state_q;
   logic [NR_OF_WBM-1:0]   gnt_q;
   logic [IW-1:0]          gidx_q;
   logic [IW-1:0]          last_q;
   logic [IW-1:0]          pick_last;
   logic [IW-1:0]          pick_idx;
   logic [NR_OF_WBM-1:0]   pick;
   logic                   pick_any;

   // While busy the owner is the reference, so at release it ranks lowest.
   assign pick_last = (state_q == StBusy) ? gidx_q : last_q;

   rr_pick #(
      .NR_OF_WBM(NR_OF_WBM)
   ) u_rr_pick (
      .req_i (m_cyc_i),
      .last_i(pick_last),
      .pick_o(pick),
      .any_o (pick_any)
   );

   always_comb begin
      pick_idx = '0;
      for (int k = 0; k < NR_OF_WBM; k++) begin
         if (pick[k]) begin
            pick_idx = k[IW-1:0];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         gnt_q   <= '0;
         gidx_q  <= '0;
         last_q  <= LastRst;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (pick_any) begin
                  state_q <= StBusy;
                  gnt_q   <= pick;
                  gidx_q  <= pick_idx;
               end
            end
            StBusy: begin
               if (!m_cyc_i[gidx_q]) begin
                  last_q <= gidx_q;
                  if (pick_any) begin
                     gnt_q  <= pick;
                     gidx_q <= pick_idx;
                  end else begin
                     state_q <= StIdle;
                     gnt_q   <= '0;
                  end
               end
            end
            default: begin
               state_q <= StIdle;
               gnt_q   <= '0;
            end
         endcase
      end
   end

   assign gnt_o = gnt_q;

   always_comb begin
      s_dat_o = '0;
      s_adr_o = '0;
      s_sel_o = '0;
      s_cti_o = '0;
      s_bte_o = '0;
      s_we_o  = 1'b0;
      s_cyc_o = 1'b0;
      s_stb_o = 1'b0;
      for (int k = 0; k < NR_OF_WBM; k++) begin
         if (gnt_q[k]) begin
            s_dat_o = m_dat_i[k*DW +: DW];
            s_adr_o = m_adr_i[k*AW +: AW];
            s_sel_o = m_sel_i[k*4 +: 4];
            s_cti_o = m_cti_i[k*3 +: 3];
            s_bte_o = m_bte_i[k*2 +: 2];
            s_we_o  = m_we_i[k];
            s_cyc_o = m_cyc_i[k];
            s_stb_o = m_stb_i[k];
         end
      end
   end

   assign m_ack_o = {NR_OF_WBM{s_ack_i}} & gnt_q;
   assign m_dat_o = s_dat_i;

endmodule

// File: tb/tb_wb_sdram_arbiter.sv
// Bench for wb_sdram_arbiter: grant-order scoreboard, bus masters and a simple SDRAM slave.
module tb_wb_sdram_arbiter;
   import wb_pkg::*;

   localparam int NM = 4;
   localparam int AW = 30;
   localparam int DW = 32;

   logic clk;
   logic rst_n;

   logic [NM*DW-1:0] m_dat_i;
   logic [NM*AW-1:0] m_adr_i;
   logic [NM*4-1:0]  m_sel_i;
   logic [NM*3-1:0]  m_cti_i;
   logic [NM*2-1:0]  m_bte_i;
   logic [NM-1:0]    m_we_i, m_cyc_i, m_stb_i;
   logic [DW-1:0]    m_dat_o;
   logic [NM-1:0]    m_ack_o;
   logic [DW-1:0]    s_dat_o;
   logic [AW-1:0]    s_adr_o;
   logic [3:0]       s_sel_o;
   logic [2:0]       s_cti_o;
   logic [1:0]       s_bte_o;
   logic             s_we_o, s_cyc_o, s_stb_o;
   logic [DW-1:0]    s_dat_i;
   logic             s_ack_i;
   logic [NM-1:0]    gnt_o;

   logic [DW-1:0] m_dat [NM];
   logic [AW-1:0] m_adr [NM];
   logic [3:0]    m_sel [NM];
   logic [2:0]    m_cti [NM];
   logic [1:0]    m_bte [NM];
   logic          m_we  [NM];
   logic          m_cyc [NM];
   logic          m_stb [NM];

   logic [31:0] mem    [1024];
   logic [31:0] shadow [1024];
   logic        s_ack_q, ack_force;
   logic [31:0] s_dat_q;

   int n_total = 0;
   int n_bad   = 0;
   int exp_q[$];

   wb_sdram_arbiter #(
      .NR_OF_WBM(NM),
      .AW(AW),
      .DW(DW)
   ) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .m_dat_i(m_dat_i),
      .m_adr_i(m_adr_i),
      .m_sel_i(m_sel_i),
      .m_cti_i(m_cti_i),
      .m_bte_i(m_bte_i),
      .m_we_i (m_we_i),
      .m_cyc_i(m_cyc_i),
      .m_stb_i(m_stb_i),
      .m_dat_o(m_dat_o),
      .m_ack_o(m_ack_o),
      .s_dat_o(s_dat_o),
      .s_adr_o(s_adr_o),
      .s_sel_o(s_sel_o),
      .s_cti_o(s_cti_o),
      .s_bte_o(s_bte_o),
      .s_we_o (s_we_o),
      .s_cyc_o(s_cyc_o),
      .s_stb_o(s_stb_o),
      .s_dat_i(s_dat_i),
      .s_ack_i(s_ack_i),
      .gnt_o  (gnt_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always_comb begin
      for (int k = 0; k < NM; k++) begin
         m_dat_i[k*DW +: DW] = m_dat[k];
         m_adr_i[k*AW +: AW] = m_adr[k];
         m_sel_i[k*4 +: 4]   = m_sel[k];
         m_cti_i[k*3 +: 3]   = m_cti[k];
         m_bte_i[k*2 +: 2]   = m_bte[k];
         m_we_i[k]           = m_we[k];
         m_cyc_i[k]          = m_cyc[k];
         m_stb_i[k]          = m_stb[k];
      end
   end

   // SDRAM stand-in: ack one cycle after each strobe, unwritten words read as ~address.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s_ack_q <= 1'b0;
         s_dat_q <= '0;
         for (int i = 0; i < 1024; i++) mem[i] <= ~i;
      end else begin
         s_ack_q <= s_cyc_o & s_stb_o & !s_ack_q;
         if (s_cyc_o && s_stb_o && !s_ack_q) begin
            if (s_we_o) mem[s_adr_o[9:0]] <= s_dat_o;
            else s_dat_q <= mem[s_adr_o[9:0]];
         end
      end
   end

   assign s_ack_i = s_ack_q | ack_force;
   assign s_dat_i = s_dat_q;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h", tag, got, exp);
      end
   endtask

   // Grant scoreboard and handover-bubble monitor.
   logic [NM-1:0] prev_gnt;
   logic          prev_scyc;
   always @(negedge clk) begin
      if (!rst_n) begin
         prev_gnt  = '0;
         prev_scyc = 1'b0;
      end else begin
         if (gnt_o != prev_gnt && gnt_o != '0) begin
            if (exp_q.size() == 0) chk("gnt_unexpected", gnt_o, 0);
            else chk("gnt_order", gnt_o, 64'(1) << exp_q.pop_front());
            if (prev_gnt != '0) begin
               chk("bubble_old", prev_scyc, 0);
               chk("bubble_new", s_cyc_o, 1);
            end
         end
         prev_gnt  = gnt_o;
         prev_scyc = s_cyc_o;
      end
   end

   task automatic do_xfer(input int k, input bit we, input logic [AW-1:0] adr,
                          input logic [DW-1:0] dat, input int beats);
      bit ok;
      m_cyc[k] = 1'b1;
      m_stb[k] = 1'b1;
      m_we[k]  = we;
      m_bte[k] = BteLinear;
      for (int b = 0; b < beats; b++) begin
         m_adr[k] = adr + AW'(b);
         m_dat[k] = dat + DW'(b);
         m_cti[k] = (beats == 1) ? CtiClassic : ((b == beats - 1) ? CtiEob : CtiIncr);
         if (we) shadow[m_adr[k][9:0]] = m_dat[k];
         ok = 1'b0;
         for (int c = 0; c < 200 && !ok; c++) begin
            @(negedge clk);
            ok = m_ack_o[k];
         end
         if (!ok) begin
            chk("ack_timeout", 0, 1);
            break;
         end
         chk("ack_onehot", m_ack_o, 64'(1) << k);
         chk("s_adr", s_adr_o, m_adr[k]);
         chk("s_we", s_we_o, we);
         if (we) chk("s_dat", s_dat_o, m_dat[k]);
         else chk("rd_dat", m_dat_o, shadow[m_adr[k][9:0]]);
         @(posedge clk);
         #1;
      end
      m_cyc[k] = 1'b0;
      m_stb[k] = 1'b0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   initial begin
      int n;
      rst_n     = 1'b0;
      ack_force = 1'b1;
      for (int i = 0; i < 1024; i++) shadow[i] = ~i;
      for (int k = 0; k < NM; k++) begin
         m_dat[k] = 32'hC0DE_0000 + k;
         m_adr[k] = 30'h3F0 + k;
         m_sel[k] = 4'hF;
         m_cti[k] = CtiIncr;
         m_bte[k] = BteWrap4;
         m_we[k]  = 1'b1;
         m_stb[k] = 1'b1;
         m_cyc[k] = 1'b0;
      end
      repeat (3) @(posedge clk);
      #1;
      chk("rst_gnt", gnt_o, 0);
      chk("rst_scyc", s_cyc_o, 0);
      chk("rst_sstb", s_stb_o, 0);
      chk("rst_swe", s_we_o, 0);
      chk("rst_sadr", s_adr_o, 0);
      chk("rst_sdat", s_dat_o, 0);
      chk("rst_ack", m_ack_o, 0);
      ack_force = 1'b0;
      for (int k = 0; k < NM; k++) m_stb[k] = 1'b0;
      rst_n = 1'b1;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         chk("idle_gnt", gnt_o, 0);
         chk("idle_scyc", s_cyc_o, 0);
      end

      // Simultaneous requests from 0, 1, 3 right after reset.
      @(posedge clk);
      #1;
      exp_q.push_back(0);
      exp_q.push_back(1);
      exp_q.push_back(3);
      fork
         do_xfer(0, 1'b1, 30'h010, 32'h1000_0000, 1);
         do_xfer(1, 1'b1, 30'h011, 32'h1100_0000, 1);
         do_xfer(3, 1'b1, 30'h013, 32'h1300_0000, 1);
      join

      // Single master 2 classic write, latency check, then read-back.
      @(posedge clk);
      #1;
      exp_q.push_back(2);
      fork
         do_xfer(2, 1'b1, 30'h100, 32'hDEAD_BEEF, 1);
         begin
            @(negedge clk);
            chk("lat_cycle_n", gnt_o, 0);
            @(negedge clk);
            chk("lat_cycle_n1", gnt_o, 4'b0100);
            chk("lat_scyc", s_cyc_o, 1);
         end
      join
      @(posedge clk);
      #1;
      exp_q.push_back(2);
      do_xfer(2, 1'b0, 30'h100, 32'h0, 1);
      chk("mem_100", mem[10'h100], 32'hDEAD_BEEF);

      // Controller ack while idle is ignored; slave port idles at zero.
      @(posedge clk);
      #1;
      @(negedge clk);
      ack_force = 1'b1;
      #1;
      chk("idle_ack", m_ack_o, 0);
      chk("idle_sadr", s_adr_o, 0);
      chk("idle_swe", s_we_o, 0);
      ack_force = 1'b0;

      // Master 1 8-beat INCR read burst, master 0 requests mid-burst.
      @(posedge clk);
      #1;
      exp_q.push_back(1);
      exp_q.push_back(0);
      fork
         do_xfer(1, 1'b0, 30'h200, 32'h0, 8);
         begin
            repeat (3) @(posedge clk);
            #1;
            do_xfer(0, 1'b1, 30'h040, 32'h5555_0000, 1);
         end
      join

      // Master 0 releases and re-requests while 2 waits: 0, 2, 0.
      @(posedge clk);
      #1;
      exp_q.push_back(0);
      exp_q.push_back(2);
      exp_q.push_back(0);
      fork
         begin
            do_xfer(0, 1'b1, 30'h050, 32'hA000_0000, 2);
            @(posedge clk);
            #1;
            do_xfer(0, 1'b1, 30'h052, 32'hA200_0000, 1);
         end
         begin
            repeat (2) @(posedge clk);
            #1;
            do_xfer(2, 1'b1, 30'h060, 32'hB000_0000, 1);
         end
      join

      // Reset asserted mid-way through a 4-beat burst on master 3.
      @(posedge clk);
      #1;
      exp_q.push_back(3);
      m_cyc[3] = 1'b1;
      m_stb[3] = 1'b1;
      m_we[3]  = 1'b1;
      m_adr[3] = 30'h300;
      m_dat[3] = 32'h3333_0000;
      m_cti[3] = CtiIncr;
      n = 0;
      for (int c = 0; c < 50 && n < 2; c++) begin
         @(negedge clk);
         if (m_ack_o[3]) n++;
      end
      chk("burst_acks", n, 2);
      #2;
      ack_force = 1'b1;
      #1;
      chk("pre_rst_gnt", gnt_o, 4'b1000);
      chk("pre_rst_ack", m_ack_o, 4'b1000);
      rst_n = 1'b0;
      #1;
      chk("async_rst_gnt", gnt_o, 0);
      chk("async_rst_scyc", s_cyc_o, 0);
      chk("async_rst_ack", m_ack_o, 0);
      ack_force = 1'b0;
      m_cyc[3]  = 1'b0;
      m_stb[3]  = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      chk("post_rst_gnt", gnt_o, 0);
      chk("sb_empty", exp_q.size(), 0);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
